// File: rtl/btn_pkg.sv
// rtl/btn_pkg.sv - shared types and helpers for the button conditioner
package btn_pkg;

    typedef enum logic {RPT_FIRST, RPT_RATE} rpt_phase_t;

    // Width holding values 0..n-1; never narrower than one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/btn_debounce_ch.sv
// rtl/btn_debounce_ch.sv - one button channel: synchroniser, stability counter,
// press/release strobes and optional auto-repeat
module btn_debounce_ch
    import btn_pkg::*;
#(
    parameter int STABLE_CYC   = 100_000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic btn_level,
    output logic btn_press,
    output logic btn_release,
    output logic btn_repeat
);

    localparam int CW = cnt_w(STABLE_CYC + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYC - 1);

    logic          s0;
    logic          s1;
    logic [CW-1:0] cnt;
    logic          accept;

    // The synchronised input has disagreed with the level long enough to flip it.
    assign accept = (s1 != btn_level) && (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0          <= 1'b0;
            s1          <= 1'b0;
            cnt         <= '0;
            btn_level   <= 1'b0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
        end else begin
            s0          <= btn_in;
            s1          <= s0;
            btn_press   <= 1'b0;
            btn_release <= 1'b0;
            if (s1 == btn_level) begin
                cnt <= '0;
            end else if (accept) begin
                btn_level   <= s1;
                cnt         <= '0;
                btn_press   <= s1;
                btn_release <= ~s1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    if (REPEAT_EN != 0) begin : g_rpt
        localparam int HMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
        localparam int HW   = cnt_w(HMAX);
        localparam logic [HW-1:0] DLY_LAST  = HW'(REPEAT_DELAY - 1);
        localparam logic [HW-1:0] RATE_LAST = HW'(REPEAT_RATE - 1);

        logic [HW-1:0] hold_cnt;
        rpt_phase_t    phase;

        // An accept while the level is high is a release, so no repeat can coincide with it.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                hold_cnt   <= '0;
                phase      <= RPT_FIRST;
                btn_repeat <= 1'b0;
            end else begin
                btn_repeat <= 1'b0;
                if (accept) begin
                    hold_cnt <= '0;
                    phase    <= RPT_FIRST;
                end else if (btn_level) begin
                    if (phase == RPT_FIRST && hold_cnt == DLY_LAST) begin
                        btn_repeat <= 1'b1;
                        hold_cnt   <= '0;
                        phase      <= RPT_RATE;
                    end else if (phase == RPT_RATE && hold_cnt == RATE_LAST) begin
                        btn_repeat <= 1'b1;
                        hold_cnt   <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + 1'b1;
                    end
                end else begin
                    hold_cnt <= '0;
                end
            end
        end
    end else begin : g_norpt
        assign btn_repeat = 1'b0;
    end

endmodule

// File: rtl/btn_debounce_array.sv
// rtl/btn_debounce_array.sv - N independent debounced button channels
module btn_debounce_array
    import btn_pkg::*;
#(
    parameter int N_CH         = 5,
    parameter int STABLE_CYC   = 100_000,
    parameter int REPEAT_EN    = 1,
    parameter int REPEAT_DELAY = 50_000_000,
    parameter int REPEAT_RATE  = 10_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] btn_in,
    output logic [N_CH-1:0] btn_level,
    output logic [N_CH-1:0] btn_press,
    output logic [N_CH-1:0] btn_release,
    output logic [N_CH-1:0] btn_repeat
);

    if (N_CH < 1 || STABLE_CYC < 1 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_param
        $error("btn_debounce_array: all parameters must be >= 1");
    end

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        btn_debounce_ch #(
            .STABLE_CYC  (STABLE_CYC),
            .REPEAT_EN   (REPEAT_EN),
            .REPEAT_DELAY(REPEAT_DELAY),
            .REPEAT_RATE (REPEAT_RATE)
        ) u_ch (
            .clk        (clk),
            .rst        (rst),
            .btn_in     (btn_in[i]),
            .btn_level  (btn_level[i]),
            .btn_press  (btn_press[i]),
            .btn_release(btn_release[i]),
            .btn_repeat (btn_repeat[i])
        );
    end

endmodule

// File: tb/tb_btn_debounce_array.sv
// tb/tb_btn_debounce_array.sv - scoreboard bench with a sample-window reference model
module tb_btn_debounce_array;

    localparam int N  = 2;
    localparam int S  = 4;
    localparam int D  = 10;
    localparam int R  = 3;
    localparam int HL = S + 2;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] btn_in = 2'b11;
    logic [N-1:0] btn_level;
    logic [N-1:0] btn_press;
    logic [N-1:0] btn_release;
    logic [N-1:0] btn_repeat;

    btn_debounce_array #(
        .N_CH        (N),
        .STABLE_CYC  (S),
        .REPEAT_EN   (1),
        .REPEAT_DELAY(D),
        .REPEAT_RATE (R)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn_in     (btn_in),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_repeat (btn_repeat)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    logic [7:0] exp_q[$];

    // Model: raw samples per edge; level flips once the S samples that the
    // debouncer currently sees (two sync stages behind) all agree on a new value.
    logic m_lvl[N];
    int   m_since[N];
    logic hist[N][HL];

    task automatic model_reset();
        for (int c = 0; c < N; c++) begin
            m_lvl[c]   = 1'b0;
            m_since[c] = 0;
            for (int i = 0; i < HL; i++) hist[c][i] = 1'b0;
        end
    endtask

    task automatic model_edge();
        logic [7:0] e;
        logic       same;
        e = 8'h00;
        if (rst) begin
            model_reset();
        end else begin
            for (int c = 0; c < N; c++) begin
                for (int i = 0; i < HL - 1; i++) hist[c][i] = hist[c][i+1];
                hist[c][HL-1] = btn_in[c];
                same = 1'b1;
                for (int i = 0; i < S; i++) if (hist[c][i] != hist[c][0]) same = 1'b0;
                if (same && hist[c][0] != m_lvl[c]) begin
                    m_lvl[c] = hist[c][0];
                    if (m_lvl[c]) e[4+c] = 1'b1;
                    else          e[2+c] = 1'b1;
                    m_since[c] = 0;
                end else if (m_lvl[c]) begin
                    m_since[c]++;
                    if (m_since[c] == D || (m_since[c] > D && (m_since[c] - D) % R == 0))
                        e[c] = 1'b1;
                end
                e[6+c] = m_lvl[c];
            end
        end
        exp_q.push_back(e);
    endtask

    task automatic step(input logic [N-1:0] v, input int n);
        repeat (n) begin
            @(negedge clk);
            btn_in = v;
            model_edge();
        end
    endtask

    task automatic rst_pulse(input logic [N-1:0] v);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        n_checks++;
        if ({btn_level, btn_press, btn_release, btn_repeat} == 8'h00) n_pass++;
        else $display("FAIL async_rst outputs got %b required 00000000",
                      {btn_level, btn_press, btn_release, btn_repeat});
        #1 rst = 1'b0;
        btn_in = v;
        model_reset();
        model_edge();
    endtask

    initial begin : monitor
        logic [7:0] e;
        logic [7:0] got;
        forever begin
            @(posedge clk);
            #1;
            cyc++;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {btn_level, btn_press, btn_release, btn_repeat};
                n_checks++;
                if (got == e) n_pass++;
                else $display("FAIL cyc%0d lvl/press/rel/rep got %b required %b", cyc, got, e);
            end
        end
    end

    initial begin : stim
        logic [N-1:0] v;
        int           rem[N];
        model_reset();
        // Reset held with both buttons down, then released.
        step(2'b11, 3);
        @(posedge clk);
        #1 rst = 1'b0;
        step(2'b11, 12);
        step(2'b00, 10);
        // Short glitches on ch0, then the S-cycle boundary.
        step(2'b01, 1); step(2'b00, 2);
        step(2'b01, 2); step(2'b00, 2);
        step(2'b01, 3); step(2'b00, 8);
        step(2'b01, 4); step(2'b00, 10);
        // Bounce then steady press and release.
        step(2'b01, 1); step(2'b00, 1); step(2'b01, 2); step(2'b00, 1);
        step(2'b01, 12); step(2'b00, 12);
        // Long hold on ch1 with repeats.
        step(2'b10, 40); step(2'b00, 10);
        // Simultaneous press, partial release.
        step(2'b11, 10); step(2'b10, 10); step(2'b00, 10);
        // Reset while ch1 is repeating, still held afterwards.
        step(2'b10, 22);
        rst_pulse(2'b10);
        step(2'b10, 30); step(2'b00, 8);
        // Randomised hold lengths mixing glitches, boundary and long holds.
        v = 2'b00;
        rem[0] = 1;
        rem[1] = 1;
        for (int i = 0; i < 2000; i++) begin
            for (int c = 0; c < N; c++) begin
                if (rem[c] == 0) begin
                    v[c] = ~v[c];
                    rem[c] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(S + 1, 40))
                                                        : int'($urandom_range(1, S));
                end
                rem[c]--;
            end
            if ($urandom_range(0, 299) == 0) rst_pulse(v);
            else step(v, 1);
        end
        step(2'b00, 3);
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() == 0) n_pass++;
        else $display("FAIL drain pending got %0d required 0", exp_q.size());
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
